// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vram_pkg
// Brief    : Shared types and defaults for the VGA frame-memory arbiter.
// Revision : 1.0
// ============================================================================
package vram_pkg;

    localparam int c_ADDR_W      = 18;
    localparam int c_DATA_W      = 8;
    localparam int c_FRAME_FIRST = 324;
    localparam int c_FRAME_LAST  = 90323;

    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shares the single-port frame RAM between display scan-out (always
//            wins) and a req/ack processor port served in display gaps.
// Revision : 1.0
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int FRAME_FIRST = c_FRAME_FIRST,
    parameter int FRAME_LAST  = c_FRAME_LAST
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);

    localparam logic [ADDR_W-1:0] c_ADDR_LO = ADDR_W'(FRAME_FIRST);
    localparam logic [ADDR_W-1:0] c_ADDR_HI = ADDR_W'(FRAME_LAST);

    state_e              state_q, state_d;
    logic                hold_we_q, hold_we_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         stall_q, stall_d;
    logic                disp_valid_q;
    logic                addr_ok;
    logic                cpu_grant;

    assign addr_ok = (cpu_addr >= c_ADDR_LO) && (cpu_addr <= c_ADDR_HI);

    always_comb begin
        state_d      = state_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        stall_d      = stall_q;
        cpu_grant    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    hold_we_d    = cpu_we;
                    hold_addr_d  = cpu_addr;
                    hold_wdata_d = cpu_wdata;
                    if (addr_ok) begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        // Out-of-range: never touches the RAM, reads complete as zero.
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                        if (!cpu_we) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (disp_req) begin
                    if (stall_q != c_STALL_MAX) begin
                        stall_d = stall_q + 16'd1;
                    end
                end else begin
                    cpu_grant = 1'b1;
                    state_d   = hold_we_q ? ST_ACK : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                rdata_d = mem_rdata;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            stall_q      <= 16'd0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            stall_q      <= stall_d;
            disp_valid_q <= disp_req;
        end
    end

    // cpu_grant already excludes disp_req, so the display owns the RAM whenever it asks.
    assign mem_addr   = cpu_grant ? hold_addr_q : disp_addr;
    assign mem_we     = cpu_grant & hold_we_q & ~rst;
    assign mem_wdata  = hold_wdata_q;

    assign cpu_ack    = (state_q == ST_ACK);
    assign cpu_err    = cpu_ack & err_q;
    assign cpu_rdata  = rdata_q;
    assign stall_cnt  = stall_q;

    assign disp_data  = mem_rdata;
    assign disp_valid = disp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed stimulus with a transaction-level model for vram_arbiter.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;

    logic        vga_clk   = 1'b0;
    logic        rst       = 1'b1;
    logic        disp_req  = 1'b0;
    logic [17:0] disp_addr = '0;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        cpu_req   = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [17:0] cpu_addr  = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_err;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [15:0] stall_cnt;

    vram_arbiter dut (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_cnt (stall_cnt)
    );

    initial forever #5 vga_clk = ~vga_clk;

    int cyc = 0;
    initial forever begin
        @(posedge vga_clk);
        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Display pattern controls (owned by the main driver)
    int disp_from = -10;
    int disp_to   = -20;
    logic per_en  = 1'b0;
    int per_base  = 0;

    // Mailboxes from driver to the compare process
    int    tx_seq   = 0;
    int    drv_start = 0;
    string lit_name = "";
    int    lit_act  = 0;
    int    lit_want = 0;
    int    lit_seq  = 0;

    // RAM contents: unwritten cells hold a fixed address pattern
    logic [7:0] ram    [int];
    logic [7:0] shadow [int];

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 7) + 3);
    endfunction

    function automatic logic [7:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : pat(a);
    endfunction

    function automatic logic [7:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : pat(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Single-port RAM, 1-cycle read latency, read-before-write
    initial begin : ram_model
        logic        s_we;
        int          s_addr;
        logic [7:0]  s_wdata;
        forever begin
            @(negedge vga_clk);
            s_we    = mem_we;
            s_addr  = int'(mem_addr);
            s_wdata = mem_wdata;
            @(posedge vga_clk);
            mem_rdata <= ram_rd(s_addr);
            if (s_we) ram[s_addr] = s_wdata;
        end
    end

    // Display request generator
    initial begin : disp_gen
        int pos;
        forever begin
            @(posedge vga_clk);
            #1;
            if (per_en && cyc >= per_base) begin
                pos       = (cyc - per_base) % 400;
                disp_req  = (pos < 300);
                disp_addr = 18'(324 + pos);
            end else begin
                disp_req  = (cyc >= disp_from) && (cyc <= disp_to);
                disp_addr = 18'(2000 + (cyc % 300));
            end
        end
    end

    // Transaction-level model and per-cycle compare
    initial begin : compare
        int         tx_seen, lit_seen;
        logic       tx_active, tx_we, tx_inr;
        int         tx_start, tx_addr, tx_issue, ack_at, exp_stall, exp_maddr;
        logic [7:0] tx_wdata, exp_rdata, exp_disp;
        logic       prev_dreq, exp_we, exp_ack;
        tx_seen = 0; lit_seen = 0; tx_active = 1'b0; tx_we = 1'b0; tx_inr = 1'b0;
        tx_start = 0; tx_addr = 0; tx_issue = -1; ack_at = -1; exp_stall = 0; exp_maddr = 0;
        tx_wdata = '0; exp_rdata = '0; exp_disp = '0; prev_dreq = 1'b0;
        forever begin
            @(negedge vga_clk);
            if (lit_seq != lit_seen) begin
                chk(lit_name, 32'(lit_act), 32'(lit_want));
                lit_seen = lit_seq;
            end
            if (rst) begin
                chk("rst_mem_we",     32'(mem_we),     32'd0);
                chk("rst_cpu_ack",    32'(cpu_ack),    32'd0);
                chk("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
                chk("rst_disp_valid", 32'(disp_valid), 32'd0);
                chk("rst_stall_cnt",  32'(stall_cnt),  32'd0);
                tx_active = 1'b0;
                tx_seen   = tx_seq;
                exp_stall = 0;
                exp_rdata = '0;
                prev_dreq = 1'b0;
            end else begin
                if (tx_seq != tx_seen) begin
                    tx_seen   = tx_seq;
                    tx_active = 1'b1;
                    tx_start  = cyc;
                    tx_we     = cpu_we;
                    tx_addr   = int'(cpu_addr);
                    tx_wdata  = cpu_wdata;
                    tx_inr    = (tx_addr >= 324) && (tx_addr <= 90323);
                    tx_issue  = -1;
                end

                chk("disp_valid", 32'(disp_valid), 32'(prev_dreq));
                if (prev_dreq) chk("disp_data", 32'(disp_data), 32'(exp_disp));

                exp_we    = 1'b0;
                exp_ack   = 1'b0;
                exp_maddr = int'(disp_addr);
                if (tx_active) begin
                    // The access goes out in the first display-free cycle after the request is seen.
                    if (tx_inr && tx_issue < 0 && cyc > tx_start && !disp_req) tx_issue = cyc;
                    if (tx_inr && cyc == tx_issue) begin
                        exp_maddr = tx_addr;
                        exp_we    = tx_we;
                        if (tx_we) chk("mem_wdata", 32'(mem_wdata), 32'(tx_wdata));
                    end
                    if (!tx_inr)           ack_at = tx_start + 1;
                    else if (tx_issue >= 0) ack_at = tx_issue + (tx_we ? 1 : 2);
                    else                    ack_at = -1;
                    exp_ack = (cyc == ack_at);
                end

                chk("mem_we",   32'(mem_we),   32'(exp_we));
                chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
                chk("cpu_ack",  32'(cpu_ack),  32'(exp_ack));

                if (exp_ack) begin
                    chk("cpu_err", 32'(cpu_err), 32'(!tx_inr));
                    if (!tx_we)      exp_rdata = tx_inr ? shadow_rd(tx_addr) : 8'h00;
                    else if (tx_inr) shadow[tx_addr] = tx_wdata;
                    tx_active = 1'b0;
                end

                chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
                chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));

                if (tx_active && tx_inr && tx_issue < 0 && cyc > tx_start && disp_req && exp_stall < 65535)
                    exp_stall++;
                prev_dreq = disp_req;
                exp_disp  = ram_rd(int'(disp_addr));
            end
        end
    end

    task automatic lit(input string nm, input int act, input int want);
        lit_name = nm;
        lit_act  = act;
        lit_want = want;
        lit_seq++;
        @(negedge vga_clk);
        #1;
    endtask

    task automatic start_txn(input logic we, input int addr, input logic [7:0] wd);
        @(posedge vga_clk);
        #2;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = 18'(addr);
        cpu_wdata = wd;
        drv_start = cyc;
        tx_seq++;
    endtask

    task automatic wait_ack(output int lat, output logic [7:0] rd, output logic er);
        int n;
        lat = -1; rd = '0; er = 1'b0; n = 0;
        while (lat < 0 && n < 2000) begin
            @(negedge vga_clk);
            n++;
            if (cpu_ack) begin
                lat = cyc - drv_start;
                rd  = cpu_rdata;
                er  = cpu_err;
            end
        end
        cpu_req = 1'b0;
        if (lat < 0) lit("ack_timeout", 0, 1);
    endtask

    task automatic do_txn(input logic we, input int addr, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output logic er);
        start_txn(we, addr, wd);
        wait_ack(lat, rd, er);
    endtask

    initial begin : driver
        int         lat, sc;
        logic [7:0] rd;
        logic       er;

        repeat (3) @(posedge vga_clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge vga_clk);

        // Uncontended write then read at the lowest legal address
        do_txn(1'b1, 324, 8'hA5, lat, rd, er);
        lit("wr324_latency", lat, 2);
        lit("wr324_err", int'(er), 0);
        do_txn(1'b0, 324, 8'h00, lat, rd, er);
        lit("rd324_latency", lat, 3);
        lit("rd324_data", int'(rd), 8'hA5);

        // Highest legal address
        do_txn(1'b1, 90323, 8'h3C, lat, rd, er);
        do_txn(1'b0, 90323, 8'h00, lat, rd, er);
        lit("rd90323_data", int'(rd), 8'h3C);

        // Display busy for 10 cycles while a write is pending
        disp_from = cyc + 1;
        disp_to   = cyc + 11;
        do_txn(1'b1, 1000, 8'h77, lat, rd, er);
        sc = int'(stall_cnt);
        lit("contended_latency", lat, 12);
        lit("contended_stall", sc, 10);
        do_txn(1'b0, 1000, 8'h00, lat, rd, er);
        lit("rd1000_data", int'(rd), 8'h77);

        // Out-of-range accesses
        do_txn(1'b1, 90324, 8'h11, lat, rd, er);
        lit("oor_wr_latency", lat, 1);
        lit("oor_wr_err", int'(er), 1);
        do_txn(1'b0, 323, 8'h00, lat, rd, er);
        lit("oor_rd_latency", lat, 1);
        lit("oor_rd_err", int'(er), 1);
        lit("oor_rd_data", int'(rd), 0);

        // 300-on / 100-off display with back-to-back writes
        per_base = cyc + 1;
        per_en   = 1'b1;
        for (int i = 0; i < 150; i++) begin
            do_txn(1'b1, 324 + i * 601, 8'((i * 13) + 1), lat, rd, er);
        end
        do_txn(1'b0, 324 + 5 * 601, 8'h00, lat, rd, er);
        per_en = 1'b0;
        lit("periodic_rdback", int'(rd), 66);
        do_txn(1'b0, 324 + 149 * 601, 8'h00, lat, rd, er);

        // Reset while a write is stalled in ISSUE
        disp_from = cyc + 1;
        disp_to   = cyc + 40;
        start_txn(1'b1, 500, 8'hEE);
        repeat (3) begin
            @(posedge vga_clk);
            #2;
        end
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge vga_clk);
        sc = int'(stall_cnt);
        lat = int'(cpu_ack);
        lit("rst_issue_stall", sc, 0);
        lit("rst_issue_ack", lat, 0);
        @(posedge vga_clk);
        #2 rst = 1'b0;
        do_txn(1'b0, 500, 8'h00, lat, rd, er);
        lit("rst_issue_nowrite", int'(rd), 8'hAF);

        // Reset while a read is in RDWAIT
        start_txn(1'b0, 1000, 8'h00);
        repeat (2) begin
            @(posedge vga_clk);
            #2;
        end
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge vga_clk);
        sc = int'(cpu_rdata);
        lit("rst_rdwait_rdata", sc, 0);
        @(posedge vga_clk);
        #2 rst = 1'b0;
        do_txn(1'b0, 1000, 8'h00, lat, rd, er);
        lit("post_rst_rd1000", int'(rd), 8'h77);

        repeat (4) @(posedge vga_clk);
        @(negedge vga_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
